div_unit: RTL
=============

Name: div_unit

Overview:
- Multi-cycle radix-2 divider: the responder side of the divide request that the execute stage issues for DIV/DIVU.
- Execute raises a start request carrying the operands, then holds it, stalling the pipeline.
- The divider iterates one quotient bit per cycle and returns {remainder, quotient} with a ready flag.
- Execute forwards that result as its HI/LO write request: remainder goes to HI, quotient to LO.

Parameters:
DATA_W, 32, operand width; quotient and remainder are DATA_W each, result is 2*DATA_W.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous reset, active-low (0 = reset)
signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled at accept
opdata1_i  input  DATA_W  dividend; sampled at accept
opdata2_i  input  DATA_W  divisor; sampled at accept
start_i  input  1  request; execute holds it high until it sees ready_o, then drops it
annul_i  input  1  cancel current/pending division (pipeline flush)
result_o  output  2*DATA_W  {remainder[63:32], quotient[31:0]}; valid only while ready_o=1
ready_o  output  1  result valid

Behaviour:
- Reset (rst=0 at a rising edge):
  - state=FREE, cnt=0, result_o=0, ready_o=0, all datapath registers cleared.
  - Reset applies from any state, including mid-division.
- FSM states: FREE, BYZERO, ON, END. All outputs are registered.
- FREE:
  - ready_o=0, result_o=0.
  - If start_i=1 and annul_i=0, the request is accepted:
    - Latch signed_div_i.
    - If opdata2_i=0, go to BYZERO.
    - Otherwise go to ON with cnt=0.
    - Latch operand magnitudes: in signed mode, a negative operand is replaced by its two's complement; in unsigned mode, operands are taken raw.
    - Latch the quotient sign (sign1 XOR sign2) and the remainder sign (sign1); both are forced to 0 in unsigned mode.
  - Otherwise stay in FREE.
- BYZERO: on the next edge, go to END with result_o=0 and ready_o=1. Divide-by-zero returns HI=0, LO=0 and raises no exception.
- ON:
  - Each edge performs one restoring step on a 2*DATA_W+1-bit working register:
    - Shift left 1.
    - Trial-subtract the divisor from the upper half.
    - If the result is non-negative, keep it and set the quotient LSB to 1; else keep the shifted value with LSB 0.
    - cnt increments.
  - After 32 steps (cnt=32), the next edge applies sign fix-up and goes to END with ready_o=1:
    - Quotient is negated if its sign bit is set.
    - Remainder is negated if its sign bit is set.
  - Operand inputs are ignored during ON.
- Latency:
  - The accepting edge is edge 1; ready_o goes high after edge 34.
  - For divide-by-zero, ready_o goes high after edge 2.
- END:
  - ready_o=1 and result_o hold while start_i=1.
  - On the first edge with start_i=0, go to FREE with ready_o=0 and result_o=0.
  - annul_i is ignored in END; the result has already been delivered.
- Annul:
  - annul_i=1 in ON or BYZERO sends the FSM to FREE on that edge, with cnt=0, ready_o=0 and result_o=0.
  - annul_i=1 in FREE blocks acceptance even when start_i=1.
  - Annul has priority over start.
- Arithmetic corner cases:
  - Signed 0x80000000 / 0xFFFFFFFF: magnitude 0x80000000 / 1 gives quotient 0x80000000 and remainder 0. The result is q=0x80000000, r=0, with no trap.
  - Remainder magnitude is always less than divisor magnitude.
  - The remainder's sign follows the dividend; a zero remainder is never negated to a nonzero value.
- Back-to-back requests: a new request can only be accepted from FREE, so there is at least one idle cycle between a drop of start_i and the next accept.

Test Plan:
- Unsigned 100/7: start=1, signed=0 -> ready_o rises after edge 34; result_o={32'd2, 32'd14}. Drop start -> ready_o=0 and result_o=0 on the next edge.
- Signed -7/2 (0xFFFFFFF9, 0x00000002) -> q=0xFFFFFFFD (-3), r=0xFFFFFFFF (-1). Also 7/-2 -> q=-3, r=+1.
- Signed 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0. Unsigned 0xFFFFFFFF/0x00000001 -> q=0xFFFFFFFF, r=0.
- Divide by zero (opdata2=0, either mode) -> ready_o high after edge 2, result_o=0. It holds until start drops.
- Annul at cycle 10 of ON -> FREE on that edge, ready_o never asserts. An immediate new request 9/3 -> q=3, r=0 after 34 edges.
- rst=0 asserted mid-ON (cycle 20) and in END -> next edge: state FREE, ready_o=0, result_o=0. Operand changes during ON do not affect the result.

Source files
------------

// File: rtl/div_unit_if.sv
// Divide request/response bundle between execute and the divider.
// master: execute (drives operands/start/annul); slave: div_unit.
interface div_unit_if #(
  parameter int DATA_W = 32
);
  logic                signed_div_i;
  logic [DATA_W-1:0]   opdata1_i;
  logic [DATA_W-1:0]   opdata2_i;
  logic                start_i;
  logic                annul_i;
  logic [2*DATA_W-1:0] result_o;
  logic                ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i,
    output start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i,
    input  start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU.
// Ports: clk, rst (sync, active-low), bus (div_unit_if.slave).
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic      clk,
  input  logic      rst,
  div_unit_if.slave bus
);

  localparam int CW = $clog2(DATA_W) + 1;
  localparam int WW = 2 * DATA_W + 1;

  typedef enum logic [1:0] {
    FREE, BYZERO, ON, END
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [WW-1:0]       work_q, work_d;
  logic [DATA_W-1:0]   dvs_q, dvs_d;
  logic                sgn_q, sgn_d;
  logic                qneg_q, qneg_d;
  logic                rneg_q, rneg_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic                ready_q, ready_d;

  logic              a_neg, b_neg;
  logic [DATA_W-1:0] mag_a, mag_b;
  logic [WW-1:0]     shifted;
  logic [DATA_W:0]   trial;
  logic [DATA_W-1:0] quo, rem;

  always_comb begin
    a_neg = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
    b_neg = bus.signed_div_i & bus.opdata2_i[DATA_W-1];
    mag_a = a_neg ? -bus.opdata1_i : bus.opdata1_i;
    mag_b = b_neg ? -bus.opdata2_i : bus.opdata2_i;
    shifted = work_q << 1;
    // Upper DATA_W+1 bits hold the partial remainder.
    trial = shifted[WW-1:DATA_W] - {1'b0, dvs_q};
    quo = work_q[DATA_W-1:0];
    rem = work_q[2*DATA_W-1:DATA_W];

    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    dvs_d    = dvs_q;
    sgn_d    = sgn_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    ready_d  = ready_q;

    unique case (state_q)
      FREE: begin
        ready_d  = 1'b0;
        result_d = '0;
        if (bus.start_i && !bus.annul_i) begin
          sgn_d  = bus.signed_div_i;
          work_d = {{(DATA_W+1){1'b0}}, mag_a};
          dvs_d  = mag_b;
          qneg_d = a_neg ^ b_neg;
          rneg_d = a_neg;
          cnt_d  = '0;
          state_d = (bus.opdata2_i == '0)
                  ? BYZERO : ON;
        end
      end
      BYZERO: begin
        if (bus.annul_i) begin
          state_d  = FREE;
          cnt_d    = '0;
          ready_d  = 1'b0;
          result_d = '0;
        end else begin
          state_d  = END;
          ready_d  = 1'b1;
          result_d = '0;
        end
      end
      ON: begin
        if (bus.annul_i) begin
          state_d  = FREE;
          cnt_d    = '0;
          ready_d  = 1'b0;
          result_d = '0;
        end else if (cnt_q == CW'(DATA_W)) begin
          result_d[DATA_W-1:0] =
            (sgn_q && qneg_q) ? -quo : quo;
          result_d[2*DATA_W-1:DATA_W] =
            (sgn_q && rneg_q) ? -rem : rem;
          ready_d = 1'b1;
          state_d = END;
        end else begin
          if (trial[DATA_W]) begin
            work_d = shifted;
          end else begin
            work_d = {trial, shifted[DATA_W-1:0]};
            work_d[0] = 1'b1;
          end
          cnt_d = cnt_q + 1'b1;
        end
      end
      END: begin
        if (!bus.start_i) begin
          state_d  = FREE;
          ready_d  = 1'b0;
          result_d = '0;
        end
      end
      default: begin
        state_d  = FREE;
        ready_d  = 1'b0;
        result_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= FREE;
      cnt_q    <= '0;
      work_q   <= '0;
      dvs_q    <= '0;
      sgn_q    <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      dvs_q    <= dvs_d;
      sgn_q    <= sgn_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;

endmodule
